// File: rtl/mon_violation_logger.sv
// mon_violation_logger
//   Condenses the err flag of an upstream property monitor into violation
//   episodes {start timestamp, duration, saturated}. Records are buffered in a
//   first-word-fall-through FIFO and drained over a valid/ready interface.
//   Running counts of qualified episodes and of episodes lost to overflow are
//   kept alongside.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   en             logging enable; err is ignored while low
//   err            monitor error flag (1 = property violated this cycle)
//   active         an episode is currently open
//   rec_valid      FIFO head record valid (FIFO not empty)
//   rec_ready      consumer accepts the head record
//   rec_ts         head record start timestamp (0 while empty)
//   rec_dur        head record duration in cycles (0 while empty)
//   rec_sat        head record duration saturated (0 while empty)
//   fifo_level     records stored, 0..DEPTH
//   viol_cnt       qualified episodes closed (stored or dropped), saturating
//   drop_cnt       qualified episodes dropped on a full FIFO, saturating
module mon_violation_logger #(
  parameter int unsigned TS_W    = 32,
  parameter int unsigned DUR_W   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_LEN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     err,
  output logic                     active,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [TS_W-1:0]          rec_ts,
  output logic [DUR_W-1:0]         rec_dur,
  output logic                     rec_sat,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         viol_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_LVL = DEPTH[AW:0];
  localparam logic [DUR_W-1:0]  MIN_DUR  = MIN_LEN[DUR_W-1:0];

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t           r_state;
  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_start_ts;
  logic [DUR_W-1:0] r_dur;
  logic             r_sat;

  logic [TS_W-1:0]  r_mem_ts  [DEPTH];
  logic [DUR_W-1:0] r_mem_dur [DEPTH];
  logic             r_mem_sat [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [CNT_W-1:0] r_viol;
  logic [CNT_W-1:0] r_drop;

  logic w_v;
  logic w_close;
  logic w_qual;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_v     = en & err;
  assign w_close = (r_state == S_ACTIVE) && !w_v;
  assign w_qual  = w_close && (r_dur >= MIN_DUR);
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = !w_empty && rec_ready;
  // A full FIFO still takes the record when the head leaves on the same edge.
  assign w_push  = w_qual && (!w_full || w_pop);
  assign w_drop  = w_qual && !w_push;

  // Timestamp and episode FSM. The closing edge always returns to IDLE, so a
  // new episode can only begin on a later edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts       <= '0;
      r_state    <= S_IDLE;
      r_start_ts <= '0;
      r_dur      <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_ts <= r_ts + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_v) begin
            r_state    <= S_ACTIVE;
            r_start_ts <= r_ts;
            r_dur      <= {{(DUR_W-1){1'b0}}, 1'b1};
            r_sat      <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_v) begin
            if (r_dur == '1) r_sat <= 1'b1;
            else             r_dur <= r_dur + 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage array carries no reset; empty-gating of the head outputs hides
  // stale contents.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_ts[r_wr_ptr]  <= r_start_ts;
      r_mem_dur[r_wr_ptr] <= r_dur;
      r_mem_sat[r_wr_ptr] <= r_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_viol <= '0;
      r_drop <= '0;
    end else begin
      if (w_qual && (r_viol != '1)) r_viol <= r_viol + 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  assign active     = (r_state == S_ACTIVE);
  assign rec_valid  = !w_empty;
  assign rec_ts     = w_empty ? '0   : r_mem_ts[r_rd_ptr];
  assign rec_dur    = w_empty ? '0   : r_mem_dur[r_rd_ptr];
  assign rec_sat    = w_empty ? 1'b0 : r_mem_sat[r_rd_ptr];
  assign fifo_level = r_level;
  assign viol_cnt   = r_viol;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_mon_violation_logger.sv
module tb_mon_violation_logger;

  localparam int TS_W    = 32;
  localparam int DUR_W   = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int MIN_LEN = 3;
  localparam int DMAX    = 15;
  localparam int CMAX    = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              err = 1'b0;
  logic              rec_ready = 1'b0;
  logic              active;
  logic              rec_valid;
  logic [TS_W-1:0]   rec_ts;
  logic [DUR_W-1:0]  rec_dur;
  logic              rec_sat;
  logic [3:0]        fifo_level;
  logic [CNT_W-1:0]  viol_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  mon_violation_logger #(
    .TS_W(TS_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .MIN_LEN(MIN_LEN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .err(err), .active(active),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts),
    .rec_dur(rec_dur), .rec_sat(rec_sat), .fifo_level(fifo_level),
    .viol_cnt(viol_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ts;
    logic [3:0]  dur;
    logic        sat;
  } rec_t;

  rec_t sb[$];
  rec_t mon_e;
  int n_vec  = 0;
  int n_miss = 0;
  int unsigned model_ts = 0;
  int exp_level = 0;
  int exp_viol  = 0;
  int exp_drop  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One clock edge; model_ts tracks the timestamp the next edge will see.
  task automatic tick();
    @(posedge clk);
    if (rst) model_ts = 0;
    else     model_ts++;
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 64'(fifo_level), 64'(exp_level));
    check({tag, "_viol"},  64'(viol_cnt),   64'(exp_viol));
    check({tag, "_drop"},  64'(drop_cnt),   64'(exp_drop));
  endtask

  // Open an episode of len violating cycles, close it on the next edge.
  task automatic episode(input int len, input bit by_en, input bit ready_on_close);
    int unsigned start;
    rec_t r;
    en = 1'b1;
    err = 1'b1;
    start = model_ts;
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 0) check("active_open", 64'(active), 64'd1);
    end
    if (by_en) en = 1'b0;
    else       err = 1'b0;
    if (ready_on_close) rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    err = 1'b0;
    en = 1'b1;
    if (len >= MIN_LEN) begin
      exp_viol = (exp_viol < CMAX) ? exp_viol + 1 : CMAX;
      if (exp_level < DEPTH || ready_on_close) begin
        r.ts  = start;
        r.dur = 4'((len > DMAX) ? DMAX : len);
        r.sat = (len > DMAX);
        sb.push_back(r);
        if (!ready_on_close) exp_level++;
      end else begin
        exp_drop = (exp_drop < CMAX) ? exp_drop + 1 : CMAX;
      end
    end
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int i = 0; i < 40 && rec_valid; i++) tick();
    rec_ready = 1'b0;
    exp_level = 0;
    check("drain_empty", 64'(rec_valid), 64'd0);
    check("drain_sb_left", 64'(sb.size()), 64'd0);
    check("empty_ts", 64'(rec_ts), 64'd0);
    check("empty_dur", 64'(rec_dur), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_level = 0;
    exp_viol  = 0;
    exp_drop  = 0;
  endtask

  // Monitor: every accepted head record is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_record: got ts=%0d dur=%0d sat=%0d, required none",
                 rec_ts, rec_dur, rec_sat);
      end else begin
        mon_e = sb.pop_front();
        check("rec_ts",  64'(rec_ts),  64'(mon_e.ts));
        check("rec_dur", 64'(rec_dur), 64'(mon_e.dur));
        check("rec_sat", 64'(rec_sat), 64'(mon_e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_level",  64'(fifo_level), 64'd0);
    check("rst_valid",  64'(rec_valid),  64'd0);
    check("rst_active", 64'(active),     64'd0);
    check("rst_ts",     64'(rec_ts),     64'd0);
    check("rst_dur",    64'(rec_dur),    64'd0);
    check("rst_sat",    64'(rec_sat),    64'd0);
    check("rst_viol",   64'(viol_cnt),   64'd0);
    check("rst_drop",   64'(drop_cnt),   64'd0);

    // T1: err high at ts 10..14, low at ts 15
    en = 1'b1;
    repeat (10) tick();
    episode(5, 1'b0, 1'b0);
    check("t1_valid",  64'(rec_valid), 64'd1);
    check("t1_head_ts", 64'(rec_ts),   64'd10);
    check("t1_active", 64'(active),    64'd0);
    check_state("t1");
    drain();

    // T2: glitch filter at MIN_LEN=3
    episode(2, 1'b0, 1'b0);
    episode(3, 1'b0, 1'b0);
    episode(1, 1'b0, 1'b0);
    check_state("t2");
    drain();

    // T3: overflow with 10 qualified episodes
    do_reset();
    for (int i = 0; i < 10; i++) episode(3, 1'b0, 1'b0);
    check_state("t3");
    check("t3_level8", 64'(fifo_level), 64'd8);
    check("t3_drop2",  64'(drop_cnt),   64'd2);

    // T4: close on a full FIFO while the head pops
    episode(3, 1'b0, 1'b1);
    check_state("t4");
    drain();

    // T5: duration saturation, boundary, en drop mid-episode
    episode(20, 1'b0, 1'b0);
    episode(15, 1'b0, 1'b0);
    episode(4, 1'b1, 1'b0);
    en = 1'b0;
    err = 1'b1;
    repeat (3) tick();
    check("t5_en_low_idle", 64'(active), 64'd0);
    err = 1'b0;
    en = 1'b1;
    check_state("t5");
    drain();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 25; i++) episode(3, 1'b0, 1'b0);
    check_state("sat");
    check("sat_viol15", 64'(viol_cnt), 64'd15);
    drain();

    // T6: reset mid-episode with records queued
    do_reset();
    for (int i = 0; i < 3; i++) episode(3, 1'b0, 1'b0);
    en = 1'b1;
    err = 1'b1;
    repeat (2) tick();
    check("t6_open", 64'(active), 64'd1);
    do_reset();
    err = 1'b0;
    check_state("t6");
    check("t6_valid",  64'(rec_valid), 64'd0);
    check("t6_active", 64'(active),    64'd0);
    episode(4, 1'b0, 1'b0);
    check("t6_start_ts", 64'(rec_ts), 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
